// File: rtl/fetcher_if.sv
// Program memory read bus between the fetch stage and instruction memory.
// The fetch stage is the master (drives the request), memory is the slave.
interface fetcher_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;

  modport master (
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data
  );

  modport slave (
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data
  );
endinterface

// File: rtl/fetcher.sv
// Instruction fetch stage: reads the instruction at the current PC from
// program memory over a valid/ready handshake and holds it for decode.
// A single-entry last-fetch buffer skips the memory round trip when the
// same PC is fetched again (branch-to-self, polling loops).
module fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             cache_invalidate,
  fetcher_if.master                        mem,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FETCHING = 3'b001,
    FETCHED  = 3'b010
  } state_t;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  state_t                             state_q, state_d;
  logic                               valid_q, valid_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   addr_q, addr_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   instr_q, instr_d;
  logic                               buf_valid_q, buf_valid_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   buf_pc_q, buf_pc_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   buf_data_q, buf_data_d;
  logic                               hit;

  // An invalidate in the same cycle as the hit decision forces a miss.
  assign hit = buf_valid_q && !cache_invalidate && (current_pc == buf_pc_q);

  // State, request and buffer registers; async reset abandons any request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      instr_q     <= '0;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= '0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_data_q  <= buf_data_d;
    end
  end

  // Next-state logic: hit/miss decision, handshake completion, decode release.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    buf_valid_d = buf_valid_q && !cache_invalidate;
    buf_pc_d    = buf_pc_q;
    buf_data_d  = buf_data_q;

    case (state_q)
      IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (hit) begin
            instr_d = buf_data_q;
            state_d = FETCHED;
          end else begin
            valid_d = 1'b1;
            addr_d  = current_pc;
            state_d = FETCHING;
          end
        end
      end
      FETCHING: begin
        if (mem.mem_read_ready) begin
          instr_d     = mem.mem_read_data;
          buf_pc_d    = addr_q;
          buf_data_d  = mem.mem_read_data;
          buf_valid_d = 1'b1;
          valid_d     = 1'b0;
          state_d     = FETCHED;
        end
      end
      FETCHED: begin
        if (core_state == CORE_DECODE) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign mem.mem_read_valid   = valid_q;
  assign mem.mem_read_address = addr_q;
  assign fetcher_state        = state_q;
  assign instruction          = instr_q;

endmodule

// File: tb/tb_fetcher.sv
// Directed testbench for fetcher with a transaction-level reference model
// and a per-cycle compare process, plus hand-computed literal checks.
module tb_fetcher;

  localparam logic [2:0] C_IDLE   = 3'b000;
  localparam logic [2:0] C_FETCH  = 3'b001;
  localparam logic [2:0] C_DECODE = 3'b010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  core_state = 3'b000;
  logic [7:0]  current_pc = 8'h00;
  logic        cache_invalidate = 1'b0;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;

  int errors = 0;
  int checks = 0;
  int reads  = 0;

  fetcher_if #(.ADDR_BITS(8), .DATA_BITS(16)) mem_bus ();

  fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .cache_invalidate (cache_invalidate),
    .mem              (mem_bus),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  // Reference model: tracks whether a request is outstanding, whether an
  // instruction is being held for decode, and the remembered last fetch.
  logic        m_pending = 1'b0;
  logic        m_holding = 1'b0;
  logic [7:0]  m_addr = 8'h00;
  logic [15:0] m_instr = 16'h0000;
  logic        m_buf_ok = 1'b0;
  logic [7:0]  m_buf_pc = 8'h00;
  logic [15:0] m_buf_data = 16'h0000;
  int          m_reads = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pending  = 1'b0;
      m_holding  = 1'b0;
      m_addr     = 8'h00;
      m_instr    = 16'h0000;
      m_buf_ok   = 1'b0;
      m_buf_pc   = 8'h00;
      m_buf_data = 16'h0000;
    end else if (m_pending) begin
      if (cache_invalidate) m_buf_ok = 1'b0;
      if (mem_bus.mem_read_ready) begin
        m_instr    = mem_bus.mem_read_data;
        m_buf_ok   = 1'b1;
        m_buf_pc   = m_addr;
        m_buf_data = mem_bus.mem_read_data;
        m_pending  = 1'b0;
        m_holding  = 1'b1;
        m_reads++;
      end
    end else if (m_holding) begin
      if (cache_invalidate) m_buf_ok = 1'b0;
      if (core_state == C_DECODE) m_holding = 1'b0;
    end else begin
      if (core_state == C_FETCH) begin
        if (m_buf_ok && !cache_invalidate && current_pc == m_buf_pc) begin
          m_instr   = m_buf_data;
          m_holding = 1'b1;
        end else begin
          m_pending = 1'b1;
          m_addr    = current_pc;
        end
      end
      if (cache_invalidate) m_buf_ok = 1'b0;
    end
  end

  // Count completed memory reads as seen on the bus
  always @(posedge clk) begin
    if (!reset && mem_bus.mem_read_valid && mem_bus.mem_read_ready) reads++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("model_state", {29'd0, fetcher_state},
                  m_pending ? 32'd1 : (m_holding ? 32'd2 : 32'd0));
      checkOutput("model_valid", {31'd0, mem_bus.mem_read_valid}, {31'd0, m_pending});
      if (m_pending)
        checkOutput("model_addr", {24'd0, mem_bus.mem_read_address}, {24'd0, m_addr});
      checkOutput("model_instr", {16'd0, instruction}, {16'd0, m_instr});
      checkOutput("model_reads", reads, m_reads);
    end
  end

  // Drive one cycle of inputs, return at the following falling edge
  task automatic applyStimulus(input logic [2:0] cs, input logic [7:0] pc,
                               input logic inv, input logic rdy,
                               input logic [15:0] data);
    core_state               = cs;
    current_pc               = pc;
    cache_invalidate         = inv;
    mem_bus.mem_read_ready   = rdy;
    mem_bus.mem_read_data    = data;
    @(negedge clk);
  endtask

  task automatic expectCycle(input string tag, input logic [2:0] st,
                             input logic vld, input logic [15:0] ins);
    checkOutput({tag, "_state"}, {29'd0, fetcher_state}, {29'd0, st});
    checkOutput({tag, "_valid"}, {31'd0, mem_bus.mem_read_valid}, {31'd0, vld});
    checkOutput({tag, "_instr"}, {16'd0, instruction}, {16'd0, ins});
  endtask

  initial begin
    int reads_before;
    mem_bus.mem_read_ready = 1'b0;
    mem_bus.mem_read_data  = 16'h0000;
    repeat (2) @(negedge clk);
    expectCycle("reset", 3'd0, 1'b0, 16'h0000);
    checkOutput("reset_addr", {24'd0, mem_bus.mem_read_address}, 32'h0);
    reset = 1'b0;

    // Unrecognised core state in IDLE: no activity
    applyStimulus(3'b101, 8'h05, 1'b0, 1'b0, 16'h0000);
    expectCycle("odd_core", 3'd0, 1'b0, 16'h0000);

    // Miss, zero wait
    applyStimulus(C_FETCH, 8'h05, 1'b0, 1'b0, 16'h0000);
    expectCycle("miss0_req", 3'd1, 1'b1, 16'h0000);
    checkOutput("miss0_addr", {24'd0, mem_bus.mem_read_address}, 32'h05);
    applyStimulus(C_IDLE, 8'h05, 1'b0, 1'b1, 16'h3123);
    expectCycle("miss0_done", 3'd2, 1'b0, 16'h3123);
    applyStimulus(C_DECODE, 8'h05, 1'b0, 1'b0, 16'h0000);
    expectCycle("decode_idle", 3'd0, 1'b0, 16'h3123);

    // Hit on pc 0x05
    reads_before = reads;
    applyStimulus(C_FETCH, 8'h05, 1'b0, 1'b0, 16'h0000);
    expectCycle("hit", 3'd2, 1'b0, 16'h3123);
    checkOutput("hit_no_read", reads, reads_before);
    applyStimulus(C_DECODE, 8'h05, 1'b0, 1'b0, 16'h0000);

    // Different pc misses
    applyStimulus(C_FETCH, 8'h06, 1'b0, 1'b0, 16'h0000);
    expectCycle("miss6_req", 3'd1, 1'b1, 16'h3123);
    checkOutput("miss6_addr", {24'd0, mem_bus.mem_read_address}, 32'h06);
    applyStimulus(C_FETCH, 8'h06, 1'b0, 1'b1, 16'h1111);
    expectCycle("miss6_done", 3'd2, 1'b0, 16'h1111);
    applyStimulus(C_DECODE, 8'h06, 1'b0, 1'b0, 16'h0000);

    // Miss with three wait cycles
    reads_before = reads;
    applyStimulus(C_FETCH, 8'h20, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(C_FETCH, 8'h20, 1'b0, 1'b0, 16'hDEAD);
      expectCycle("wait_hold", 3'd1, 1'b1, 16'h1111);
      checkOutput("wait_addr", {24'd0, mem_bus.mem_read_address}, 32'h20);
    end
    applyStimulus(C_FETCH, 8'h20, 1'b0, 1'b1, 16'hBEEF);
    expectCycle("wait_done", 3'd2, 1'b0, 16'hBEEF);
    checkOutput("wait_one_read", reads, reads_before + 1);
    applyStimulus(C_DECODE, 8'h20, 1'b0, 1'b0, 16'h0000);

    // Reload pc 0x05 into the buffer, then invalidate in IDLE
    applyStimulus(C_FETCH, 8'h05, 1'b0, 1'b0, 16'h0000);
    applyStimulus(C_IDLE, 8'h05, 1'b0, 1'b1, 16'h3123);
    applyStimulus(C_DECODE, 8'h05, 1'b0, 1'b0, 16'h0000);
    applyStimulus(C_IDLE, 8'h05, 1'b1, 1'b0, 16'h0000);
    applyStimulus(C_FETCH, 8'h05, 1'b0, 1'b0, 16'h0000);
    expectCycle("inval_miss", 3'd1, 1'b1, 16'h3123);
    applyStimulus(C_IDLE, 8'h05, 1'b0, 1'b1, 16'h9A07);
    expectCycle("inval_done", 3'd2, 1'b0, 16'h9A07);
    applyStimulus(C_DECODE, 8'h05, 1'b0, 1'b0, 16'h0000);

    // Invalidate together with a would-be hit forces a miss; invalidate
    // together with completion leaves the new entry valid
    applyStimulus(C_FETCH, 8'h05, 1'b1, 1'b0, 16'h0000);
    expectCycle("inval_hit_miss", 3'd1, 1'b1, 16'h9A07);
    applyStimulus(C_IDLE, 8'h05, 1'b1, 1'b1, 16'h7777);
    expectCycle("inval_complete", 3'd2, 1'b0, 16'h7777);
    applyStimulus(C_DECODE, 8'h05, 1'b0, 1'b0, 16'h0000);
    applyStimulus(C_FETCH, 8'h05, 1'b0, 1'b0, 16'h0000);
    expectCycle("complete_wins", 3'd2, 1'b0, 16'h7777);
    applyStimulus(C_DECODE, 8'h05, 1'b0, 1'b0, 16'h0000);

    // Core leaves FETCH mid-request: request still completes
    applyStimulus(C_FETCH, 8'h40, 1'b0, 1'b0, 16'h0000);
    applyStimulus(C_IDLE, 8'h40, 1'b0, 1'b0, 16'h0000);
    applyStimulus(C_IDLE, 8'h40, 1'b0, 1'b0, 16'h0000);
    expectCycle("leave_hold", 3'd1, 1'b1, 16'h7777);
    applyStimulus(C_IDLE, 8'h40, 1'b0, 1'b1, 16'h4242);
    expectCycle("leave_done", 3'd2, 1'b0, 16'h4242);
    applyStimulus(C_IDLE, 8'h40, 1'b0, 1'b0, 16'h0000);
    expectCycle("leave_stay", 3'd2, 1'b0, 16'h4242);
    applyStimulus(C_DECODE, 8'h40, 1'b0, 1'b0, 16'h0000);

    // Spurious ready while idle is ignored
    reads_before = reads;
    applyStimulus(C_IDLE, 8'h40, 1'b0, 1'b1, 16'hFFFF);
    applyStimulus(C_IDLE, 8'h41, 1'b0, 1'b1, 16'hFFFF);
    expectCycle("spurious", 3'd0, 1'b0, 16'h4242);
    checkOutput("spurious_reads", reads, reads_before);
    applyStimulus(C_FETCH, 8'h40, 1'b0, 1'b0, 16'h0000);
    expectCycle("spurious_hit", 3'd2, 1'b0, 16'h4242);
    applyStimulus(C_DECODE, 8'h40, 1'b0, 1'b0, 16'h0000);

    // Asynchronous reset in the middle of a request
    applyStimulus(C_FETCH, 8'h33, 1'b0, 1'b0, 16'h0000);
    expectCycle("pre_reset", 3'd1, 1'b1, 16'h4242);
    core_state = C_IDLE;
    #2 reset = 1'b1;
    #1 expectCycle("async_reset", 3'd0, 1'b0, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(C_FETCH, 8'h40, 1'b0, 1'b0, 16'h0000);
    expectCycle("post_reset_miss", 3'd1, 1'b1, 16'h0000);
    checkOutput("post_reset_addr", {24'd0, mem_bus.mem_read_address}, 32'h40);
    applyStimulus(C_IDLE, 8'h40, 1'b0, 1'b1, 16'h1234);
    expectCycle("post_reset_done", 3'd2, 1'b0, 16'h1234);
    applyStimulus(C_DECODE, 8'h40, 1'b0, 1'b0, 16'h0000);
    applyStimulus(C_IDLE, 8'h40, 1'b0, 1'b0, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
